// File: rtl/fmesh_destp_encoder.sv
// fmesh_destp_encoder: two-stage valid/ready pipeline that turns a mesh
// endpoint address {ep,ey,ex} into the 4-bit {x,y,a,b} destination-port code
// and local endpoint index for the router at (cur_x, cur_y).
// Build macro FMESH_ADDR_CHECK_EN: requests naming a router or port that does
// not exist are consumed, dropped, flagged in err_addr and counted in drop_cnt.
module fmesh_destp_encoder #(
  parameter int unsigned T1         = 4,
  parameter int unsigned T2         = 4,
  parameter int unsigned T3         = 2,
  parameter int unsigned EAw        = 7,
  parameter string       ROUTE_TYPE = "DETERMINISTIC",
  parameter int unsigned PLw        = 1,
  parameter int unsigned DATAw      = 32,
  parameter int unsigned CNTw       = 8,
  localparam int unsigned EXw       = $clog2(T1),
  localparam int unsigned EYw       = $clog2(T2),
  localparam int unsigned EPw       = EAw - EXw - EYw
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [EXw-1:0]   cur_x,
  input  logic [EYw-1:0]   cur_y,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [EAw-1:0]   in_dest_e_addr,
  input  logic [DATAw-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [3:0]       out_dest_port_coded,
  output logic [PLw-1:0]   out_endp_localp_num,
  output logic [DATAw-1:0] out_data,
  output logic             err_addr,
  output logic [CNTw-1:0]  drop_cnt
);

  localparam int unsigned P        = 4 + T3;
  localparam bit          ADAPTIVE = (ROUTE_TYPE != "DETERMINISTIC");

  // The endpoint field has to be wide enough to name every router port.
  if ((32'd1 << EPw) < P) begin : g_bad_ep_width
    $error("fmesh_destp_encoder: EAw too narrow for T1/T2/T3");
  end

  logic [EXw-1:0]   dest_x;
  logic [EYw-1:0]   dest_y;
  logic [EPw-1:0]   dest_ep;
  logic             adv1;
  logic             adv2;
  logic             accept;
  logic             addr_ok;

  logic             s1_valid;
  logic [EPw-1:0]   s1_ep;
  logic             s1_dx_nz;
  logic             s1_dy_nz;
  logic             s1_east;
  logic             s1_north;
  logic [DATAw-1:0] s1_data;

  logic             s2_valid;
  logic [3:0]       enc_coded;
  logic [PLw-1:0]   enc_localp;

  assign dest_x  = in_dest_e_addr[EXw-1:0];
  assign dest_y  = in_dest_e_addr[EXw +: EYw];
  assign dest_ep = in_dest_e_addr[EXw+EYw +: EPw];

  // Each stage advances when it is empty or its successor can take its contents.
  assign adv2      = ~s2_valid | out_ready;
  assign adv1      = ~s1_valid | adv2;
  assign in_ready  = adv1;
  assign accept    = in_valid & adv1;
  assign out_valid = s2_valid;

`ifdef FMESH_ADDR_CHECK_EN
  assign addr_ok = (32'(dest_x) <= T1 - 32'd1) &&
                   (32'(dest_y) <= T2 - 32'd1) &&
                   (32'(dest_ep) <= P - 32'd1);

  // Sticky error flag and saturating count of dropped requests.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      err_addr <= 1'b0;
      drop_cnt <= '0;
    end else if (accept && !addr_ok) begin
      err_addr <= 1'b1;
      if (drop_cnt != {CNTw{1'b1}}) drop_cnt <= drop_cnt + CNTw'(1);
    end
  end
`else
  assign addr_ok  = 1'b1;
  assign err_addr = 1'b0;
  assign drop_cnt = '0;
`endif

  // Stage 1: capture endpoint index and router-relative comparisons at accept.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      s1_valid <= 1'b0;
      s1_ep    <= '0;
      s1_dx_nz <= 1'b0;
      s1_dy_nz <= 1'b0;
      s1_east  <= 1'b0;
      s1_north <= 1'b0;
      s1_data  <= '0;
    end else if (adv1) begin
      s1_valid <= accept & addr_ok;
      if (accept && addr_ok) begin
        s1_ep    <= dest_ep;
        s1_dx_nz <= (dest_x != cur_x);
        s1_dy_nz <= (dest_y != cur_y);
        s1_east  <= (dest_x > cur_x);
        s1_north <= (dest_y < cur_y);
        s1_data  <= in_data;
      end
    end
  end

  // Port code: X first, Y second; adaptive mode offers both when both differ.
  always_comb begin
    enc_coded  = 4'b0000;
    enc_localp = '0;
    if (ADAPTIVE && s1_dx_nz && s1_dy_nz) begin
      enc_coded = {s1_east, s1_north, 2'b11};
    end else if (s1_dx_nz) begin
      enc_coded = {s1_east, 1'b0, 2'b10};
    end else if (s1_dy_nz) begin
      enc_coded = {1'b0, s1_north, 2'b01};
    end else begin
      case (32'(s1_ep))
        32'd1:   enc_coded = 4'b1010;
        32'd2:   enc_coded = 4'b0101;
        32'd3:   enc_coded = 4'b0010;
        32'd4:   enc_coded = 4'b0001;
        default: enc_coded = 4'b0000;
      endcase
    end
    if (32'(s1_ep) >= 32'd5) enc_localp = PLw'(32'(s1_ep) - 32'd4);
  end

  // Stage 2: registered result, held while the consumer stalls.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      s2_valid            <= 1'b0;
      out_dest_port_coded <= 4'b0000;
      out_endp_localp_num <= '0;
      out_data            <= '0;
    end else if (adv2) begin
      s2_valid <= s1_valid;
      if (s1_valid) begin
        out_dest_port_coded <= enc_coded;
        out_endp_localp_num <= enc_localp;
        out_data            <= s1_data;
      end
    end
  end

endmodule

// File: tb/tb_fmesh_destp_encoder.sv
// Bench for fmesh_destp_encoder: a deterministic and an adaptive instance
// share one stimulus stream; a scoreboard of expected results is built from
// mesh routing rules at accept time and compared at the outputs.
module tb_fmesh_destp_encoder;

  localparam int unsigned NX  = 4;
  localparam int unsigned NY  = 4;
  localparam int unsigned NL  = 2;
  localparam int unsigned NP  = 4 + NL;
  localparam int unsigned PLW = 1;

  typedef struct {
    logic [3:0]     det;
    logic [3:0]     ad;
    logic [PLW-1:0] lp;
    logic [31:0]    data;
  } exp_t;

  logic           clk = 1'b0;
  logic           reset = 1'b1;
  logic [1:0]     cur_x = '0;
  logic [1:0]     cur_y = '0;
  logic           in_valid = 1'b0;
  logic [6:0]     in_dest_e_addr = '0;
  logic [31:0]    in_data = '0;
  logic           out_ready = 1'b0;

  logic           in_ready, out_valid, err_addr;
  logic [3:0]     out_dest_port_coded;
  logic [PLW-1:0] out_endp_localp_num;
  logic [31:0]    out_data;
  logic [7:0]     drop_cnt;

  logic           ad_in_ready, ad_out_valid, ad_err;
  logic [3:0]     ad_coded;
  logic [PLW-1:0] ad_localp;
  logic [31:0]    ad_data;
  logic [7:0]     ad_drop;

  int   n_vec = 0;
  int   n_miss = 0;
  exp_t sb[$];
  int   exp_drop = 0;
  bit   exp_err = 1'b0;
  bit   last_acc = 1'b0;
  int   acc_cnt = 0;

  always #5 clk = ~clk;

  fmesh_destp_encoder u_det (
    .clk(clk), .reset(reset), .cur_x(cur_x), .cur_y(cur_y),
    .in_valid(in_valid), .in_ready(in_ready), .in_dest_e_addr(in_dest_e_addr),
    .in_data(in_data), .out_valid(out_valid), .out_ready(out_ready),
    .out_dest_port_coded(out_dest_port_coded), .out_endp_localp_num(out_endp_localp_num),
    .out_data(out_data), .err_addr(err_addr), .drop_cnt(drop_cnt)
  );

  fmesh_destp_encoder #(.ROUTE_TYPE("ADAPTIVE")) u_ad (
    .clk(clk), .reset(reset), .cur_x(cur_x), .cur_y(cur_y),
    .in_valid(in_valid), .in_ready(ad_in_ready), .in_dest_e_addr(in_dest_e_addr),
    .in_data(in_data), .out_valid(ad_out_valid), .out_ready(out_ready),
    .out_dest_port_coded(ad_coded), .out_endp_localp_num(ad_localp),
    .out_data(ad_data), .err_addr(ad_err), .drop_cnt(ad_drop)
  );

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_miss++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Routing reference: move in X first, then Y, then deliver locally.
  function automatic logic [3:0] ref_port(input int cx, input int cy, input int addr, input bit adaptive);
    int ex, ey, ep;
    bit go_east, go_north, x_move, y_move;
    ex = addr % NX;
    ey = (addr / NX) % NY;
    ep = addr / (NX * NY);
    go_east  = ex > cx;
    go_north = ey < cy;
    x_move   = ex != cx;
    y_move   = ey != cy;
    if (adaptive && x_move && y_move) return {go_east, go_north, 2'b11};
    if (x_move) return {go_east, 1'b0, 2'b10};
    if (y_move) return {1'b0, go_north, 2'b01};
    case (ep)
      1: return 4'b1010;
      2: return 4'b0101;
      3: return 4'b0010;
      4: return 4'b0001;
      default: return 4'b0000;
    endcase
  endfunction

  function automatic logic [PLW-1:0] ref_localp(input int addr);
    int ep;
    ep = addr / (NX * NY);
    if (ep >= 5) return PLW'((ep - 4) % (1 << PLW));
    return '0;
  endfunction

  function automatic bit addr_bad(input int addr);
`ifdef FMESH_ADDR_CHECK_EN
    return ((addr % NX) > NX - 1) || (((addr / NX) % NY) > NY - 1) || ((addr / (NX * NY)) > NP - 1);
`else
    return (addr < 0);
`endif
  endfunction

  // Monitor: sampled on the falling edge, away from the active edge.
  always @(negedge clk) begin
    exp_t e;
    int   a;
    last_acc = 1'b0;
    if (reset) begin
      sb.delete();
      exp_err  = 1'b0;
      exp_drop = 0;
    end else begin
      check_eq("err_addr", 64'(err_addr), 64'(exp_err));
      check_eq("drop_cnt", 64'(drop_cnt), 64'(exp_drop));
      check_eq("ad_drop_cnt", 64'(ad_drop), 64'(exp_drop));
      check_eq("ad_err_addr", 64'(ad_err), 64'(exp_err));
      if (sb.size() == 0) begin
        check_eq("spurious_valid", 64'(out_valid | ad_out_valid), 64'd0);
      end else if (out_valid) begin
        check_eq("ad_out_valid", 64'(ad_out_valid), 64'd1);
        check_eq("coded_det", 64'(out_dest_port_coded), 64'(sb[0].det));
        check_eq("coded_ad", 64'(ad_coded), 64'(sb[0].ad));
        check_eq("localp", 64'(out_endp_localp_num), 64'(sb[0].lp));
        check_eq("ad_localp", 64'(ad_localp), 64'(sb[0].lp));
        check_eq("data", 64'(out_data), 64'(sb[0].data));
        check_eq("ad_data", 64'(ad_data), 64'(sb[0].data));
        if (out_ready) void'(sb.pop_front());
      end
      if (in_valid && in_ready) begin
        last_acc = 1'b1;
        acc_cnt++;
        a = int'(in_dest_e_addr);
        if (addr_bad(a)) begin
          exp_err = 1'b1;
          if (exp_drop < 255) exp_drop++;
        end else begin
          e.det  = ref_port(int'(cur_x), int'(cur_y), a, 1'b0);
          e.ad   = ref_port(int'(cur_x), int'(cur_y), a, 1'b1);
          e.lp   = ref_localp(a);
          e.data = in_data;
          sb.push_back(e);
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [6:0] good_addr();
    return {3'($urandom_range(0, 5)), 4'($urandom)};
  endfunction

  // One request into an idle pipeline; checks latency and both encodings.
  task automatic send_one(input string tag, input int cx, input int cy, input logic [6:0] addr,
                          input logic [3:0] exp_det, input logic [3:0] exp_ad, input logic [PLW-1:0] exp_lp);
    int n;
    logic [31:0] d;
    n = 0;
    d = $urandom;
    cur_x = 2'(cx);
    cur_y = 2'(cy);
    in_dest_e_addr = addr;
    in_data = d;
    out_ready = 1'b1;
    in_valid = 1'b1;
    check_eq({tag, "_in_ready"}, 64'(in_ready), 64'd1);
    do begin
      tick();
      in_valid = 1'b0;
      n++;
    end while (!out_valid && n < 10);
    check_eq({tag, "_latency"}, 64'(n), 64'd2);
    check_eq({tag, "_det"}, 64'(out_dest_port_coded), 64'(exp_det));
    check_eq({tag, "_ad"}, 64'(ad_coded), 64'(exp_ad));
    check_eq({tag, "_localp"}, 64'(out_endp_localp_num), 64'(exp_lp));
    check_eq({tag, "_data"}, 64'(out_data), 64'(d));
    tick();
  endtask

  task automatic drain(input string tag);
    int c;
    c = 0;
    in_valid = 1'b0;
    out_ready = 1'b1;
    while (sb.size() != 0 && c < 100) begin
      tick();
      c++;
    end
    tick();
    tick();
    check_eq({tag, "_drained"}, 64'(sb.size()), 64'd0);
  endtask

  task automatic run_random(input string tag, input int n_items, input int ready_pct);
    int sent, cyc;
    sent = 0;
    cyc = 0;
    in_valid = 1'b0;
    while ((sent < n_items || in_valid) && cyc < 5000) begin
      tick();
      cyc++;
      if (in_valid && last_acc) begin
        in_valid = 1'b0;
        sent++;
      end
      if (!in_valid && sent < n_items && $urandom_range(0, 3) != 0) begin
        if ($urandom_range(0, 3) == 0) begin
          cur_x = 2'($urandom);
          cur_y = 2'($urandom);
        end
        in_dest_e_addr = 7'($urandom);
        in_data = $urandom;
        in_valid = 1'b1;
      end
      out_ready = ($urandom_range(0, 99) < ready_pct);
    end
    check_eq({tag, "_sent"}, 64'(sent), 64'(n_items));
    drain(tag);
  endtask

  initial begin : watchdog
    #600000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin : stim
    int idx, acc, c, acc0;
    bit seen;
    logic [6:0] items [3];

    repeat (3) @(posedge clk);
    #3 reset = 1'b0;
    #1;
    check_eq("rst_in_ready", 64'(in_ready), 64'd1);
    check_eq("rst_out_valid", 64'(out_valid), 64'd0);
    check_eq("rst_coded", 64'(out_dest_port_coded), 64'd0);
    check_eq("rst_localp", 64'(out_endp_localp_num), 64'd0);
    check_eq("rst_data", 64'(out_data), 64'd0);
    check_eq("rst_err", 64'(err_addr), 64'd0);
    check_eq("rst_drop", 64'(drop_cnt), 64'd0);
    tick();

    send_one("east_0x07", 1, 1, 7'h07, 4'b1010, 4'b1010, 1'b0);
    send_one("local_ep5", 1, 1, 7'h55, 4'b0000, 4'b0000, 1'b1);
    send_one("north_0x21", 1, 1, 7'h21, 4'b0101, 4'b0101, 1'b0);
    send_one("south_0x18", 0, 0, 7'h18, 4'b0001, 4'b0001, 1'b0);
    send_one("local_ep3", 0, 0, 7'h30, 4'b0010, 4'b0010, 1'b0);
    send_one("diag_0x0f", 1, 1, 7'h0F, 4'b1010, 4'b1011, 1'b0);
    send_one("west_0x04", 2, 1, 7'h04, 4'b0010, 4'b0010, 1'b0);
    send_one("local_ep6", 3, 2, 7'h6B, 4'b0000, 4'b0000, 1'b0);

`ifdef FMESH_ADDR_CHECK_EN
    cur_x = 2'd0;
    cur_y = 2'd0;
    in_dest_e_addr = 7'h70;
    in_valid = 1'b1;
    out_ready = 1'b1;
    tick();
    in_valid = 1'b0;
    seen = 1'b0;
    repeat (4) begin
      tick();
      seen = seen | out_valid;
    end
    check_eq("bad_not_fwd", 64'(seen), 64'd0);
    check_eq("bad_err", 64'(err_addr), 64'd1);
    check_eq("bad_drop", 64'(drop_cnt), 64'd1);
    send_one("after_bad", 1, 1, 7'h07, 4'b1010, 4'b1010, 1'b0);
`else
    send_one("ep7_fwd", 0, 0, 7'h70, 4'b0000, 4'b0000, 1'b1);
    check_eq("nochk_err", 64'(err_addr), 64'd0);
    check_eq("nochk_drop", 64'(drop_cnt), 64'd0);
`endif

    acc0 = acc_cnt;
    out_ready = 1'b1;
    for (int i = 0; i < 300; i++) begin
      in_dest_e_addr = {3'b111, 4'($urandom)};
      in_data = $urandom;
      in_valid = 1'b1;
      tick();
    end
    in_valid = 1'b0;
    check_eq("bad300_accepts", 64'(acc_cnt - acc0), 64'd300);
`ifdef FMESH_ADDR_CHECK_EN
    check_eq("bad300_drop_sat", 64'(drop_cnt), 64'd255);
    check_eq("bad300_err", 64'(err_addr), 64'd1);
`else
    check_eq("bad300_drop", 64'(drop_cnt), 64'd0);
`endif
    drain("bad300");

    run_random("rand_fast", 400, 70);
    run_random("rand_slow", 300, 30);

    // Back-pressure: three back-to-back requests while the consumer stalls.
    for (int i = 0; i < 3; i++) items[i] = good_addr();
    out_ready = 1'b0;
    idx = 0;
    acc = 0;
    in_dest_e_addr = items[0];
    in_data = $urandom;
    in_valid = 1'b1;
    for (int k = 0; k < 5; k++) begin
      tick();
      if (in_valid && last_acc) begin
        acc++;
        idx++;
        if (idx < 3) begin
          in_dest_e_addr = items[idx];
          in_data = $urandom;
        end else begin
          in_valid = 1'b0;
        end
      end
    end
    check_eq("stall_accepted", 64'(acc), 64'd2);
    check_eq("stall_in_ready", 64'(in_ready), 64'd0);
    check_eq("stall_out_valid", 64'(out_valid), 64'd1);
    out_ready = 1'b1;
    c = 0;
    while (idx < 3 && c < 20) begin
      tick();
      c++;
      if (in_valid && last_acc) begin
        idx++;
        in_valid = 1'b0;
      end
    end
    check_eq("stall_all_accepted", 64'(idx), 64'd3);
    drain("stall");

    // Reset pulse with a full, stalled pipeline.
    out_ready = 1'b0;
    in_dest_e_addr = good_addr();
    in_data = $urandom;
    in_valid = 1'b1;
    repeat (3) begin
      tick();
      if (last_acc) begin
        in_dest_e_addr = good_addr();
        in_data = $urandom;
      end
    end
    check_eq("prerst_out_valid", 64'(out_valid), 64'd1);
    reset = 1'b1;
    in_valid = 1'b0;
    #1;
    check_eq("midrst_out_valid", 64'(out_valid), 64'd0);
    check_eq("midrst_ad_out_valid", 64'(ad_out_valid), 64'd0);
    check_eq("midrst_coded", 64'(out_dest_port_coded), 64'd0);
    check_eq("midrst_localp", 64'(out_endp_localp_num), 64'd0);
    check_eq("midrst_data", 64'(out_data), 64'd0);
    check_eq("midrst_drop", 64'(drop_cnt), 64'd0);
    @(negedge clk);
    @(posedge clk);
    #3 reset = 1'b0;
    #1;
    check_eq("postrst_in_ready", 64'(in_ready), 64'd1);
    check_eq("postrst_ad_in_ready", 64'(ad_in_ready), 64'd1);
    out_ready = 1'b1;
    seen = 1'b0;
    repeat (5) begin
      tick();
      seen = seen | out_valid | ad_out_valid;
    end
    check_eq("postrst_no_stale", 64'(seen), 64'd0);

    run_random("rand_after_rst", 100, 50);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
